// File: rtl/fetch_decode_pipe.sv
// -----------------------------------------------------------------------------
// fetch_decode_pipe
//
// Instruction fetch + decode front end with a registered IF/ID boundary.
// Owns the PC, presents it combinationally as the instruction-memory address,
// decodes the returned word and registers the control/operand bundle that the
// execute stage consumes.
//
// Update priority per edge: redirect > stall > advance.
//   - redirect: PC <= target, ID becomes a bubble (one-cycle penalty).
//   - stall:    PC and every ID register hold.
//   - advance:  PC <= PC + 4 (wraps), ID loads the decode of instr_data_i.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an illegal decode halts the block (HALT state), illegal_o is
//               sticky, PC frozen at offending address + 4, redirect/stall are
//               ignored; only rst_n leaves HALT.
//   undefined : an illegal word becomes a bubble, illegal_o pulses for that
//               ID cycle and fetch carries on.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   stall_i               hold PC and IF/ID register
//   redirect_i            taken branch/jump resolved downstream
//   redirect_pc_i         redirect target
//   instr_addr_o          PC (combinational copy of the PC register)
//   instr_data_i          instruction word for instr_addr_o, same cycle
//   id_valid_o            ID bundle holds a real instruction
//   id_pc_o               PC of the ID instruction
//   rs1_o, rs2_o, rd_o    register indices
//   imm_o                 sign-extended immediate
//   reg_write_o .. jump_o control bits (write/mem/branch/jump gated by valid)
//   alu_ctrl_o            000 add 001 sub 010 and 011 or 100 xor 101 slt
//                         110 sll 111 srl
//   illegal_o             illegal-instruction flag
// -----------------------------------------------------------------------------
module fetch_decode_pipe #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic [ADDRESS_WIDTH-1:0] instr_addr_o,
  input  logic [DATA_WIDTH-1:0]    instr_data_i,
  output logic                     id_valid_o,
  output logic [ADDRESS_WIDTH-1:0] id_pc_o,
  output logic [4:0]               rs1_o,
  output logic [4:0]               rs2_o,
  output logic [4:0]               rd_o,
  output logic [DATA_WIDTH-1:0]    imm_o,
  output logic                     reg_write_o,
  output logic                     alu_src_o,
  output logic                     mem_write_o,
  output logic                     mem_to_reg_o,
  output logic                     branch_o,
  output logic                     jump_o,
  output logic [2:0]               alu_ctrl_o,
  output logic                     illegal_o
);

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Registered IF/ID bundle
  typedef struct packed {
    logic                     valid;
    logic                     illegal;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     reg_write;
    logic                     alu_src;
    logic                     mem_write;
    logic                     mem_to_reg;
    logic                     branch;
    logic                     jump;
    logic [2:0]               alu_ctrl;
  } id_t;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  id_t                      id_q, id_d;
  id_t                      dec;
  logic                     dec_illegal;
  logic                     halted;
  logic                     advance;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_data_i[6:0];
  assign funct3 = instr_data_i[14:12];
  assign funct7 = instr_data_i[31:25];

  assign imm_i = {{20{instr_data_i[31]}}, instr_data_i[31:20]};
  assign imm_s = {{20{instr_data_i[31]}}, instr_data_i[31:25], instr_data_i[11:7]};
  assign imm_b = {{19{instr_data_i[31]}}, instr_data_i[31], instr_data_i[7],
                  instr_data_i[30:25], instr_data_i[11:8], 1'b0};
  assign imm_u = {instr_data_i[31:12], 12'b0};
  assign imm_j = {{11{instr_data_i[31]}}, instr_data_i[31], instr_data_i[19:12],
                  instr_data_i[20], instr_data_i[30:21], 1'b0};

  // funct3 -> ALU op for the shared R/I operation set (sub handled separately)
  function automatic logic [2:0] alu_of(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_of = ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      3'b111:  alu_of = ALU_AND;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

  // Widen a 32-bit immediate to DATA_WIDTH with sign extension
  function automatic logic [DATA_WIDTH-1:0] sext(input logic [31:0] v);
    sext = DATA_WIDTH'(signed'(v));
  endfunction

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    dec.rd      = instr_data_i[11:7];
    dec.rs1     = instr_data_i[19:15];
    dec.rs2     = instr_data_i[24:20];
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        // funct3 011 (sltu) and funct7[5] variants other than sub are not supported
        if (funct7 == 7'b0000000 && funct3 != 3'b011)
          dec.alu_ctrl = alu_of(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000)
          dec.alu_ctrl = ALU_SUB;
        else
          dec_illegal = 1'b1;
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = sext(imm_i);
        // shifts carry funct7 in the immediate; only the logical form is legal
        if (funct3 == 3'b011)
          dec_illegal = 1'b1;
        else if ((funct3 == 3'b001 || funct3 == 3'b101) && funct7 != 7'b0000000)
          dec_illegal = 1'b1;
        else
          dec.alu_ctrl = alu_of(funct3);
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.imm        = sext(imm_i);
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm       = sext(imm_s);
      end
      OP_BRANCH: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        dec.imm      = sext(imm_b);
        if (funct3 != 3'b000 && funct3 != 3'b001)
          dec_illegal = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.rs1       = 5'd0;
        dec.imm       = sext(imm_u);
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = sext(imm_j);
      end
      default: dec_illegal = 1'b1;
    endcase
    // An illegal word carries no operands or side effects into ID
    if (dec_illegal) dec = '0;
  end

  // ---------------------------------------------------------------------------
  // RUN/HALT control
  // ---------------------------------------------------------------------------
  assign advance = !halted && !redirect_i && !stall_i;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic {RUN, HALT} state_e;
  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && advance && dec_illegal) state_d = HALT;
  end

  always_comb begin
    halted = (state_q == HALT);
  end
`else
  assign halted = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // PC and IF/ID update
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d = pc_q;
    id_d = id_q;
    if (halted) begin
      // frozen: PC, illegal flag and the bubble all hold until reset
      id_d.valid = 1'b0;
    end else if (redirect_i) begin
      pc_d         = redirect_pc_i;
      id_d.valid   = 1'b0;
      id_d.illegal = 1'b0;
    end else if (advance) begin
      pc_d         = pc_q + ADDRESS_WIDTH'(4);
      id_d         = dec;
      id_d.pc      = pc_q;
      id_d.valid   = !dec_illegal;
      id_d.illegal = dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      id_q <= '0;
    end else begin
      pc_q <= pc_d;
      id_q <= id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs; side-effecting controls are masked for bubbles
  // ---------------------------------------------------------------------------
  assign instr_addr_o = pc_q;
  assign id_valid_o   = id_q.valid;
  assign id_pc_o      = id_q.pc;
  assign rs1_o        = id_q.rs1;
  assign rs2_o        = id_q.rs2;
  assign rd_o         = id_q.rd;
  assign imm_o        = id_q.imm;
  assign reg_write_o  = id_q.reg_write & id_q.valid;
  assign alu_src_o    = id_q.alu_src;
  assign mem_write_o  = id_q.mem_write & id_q.valid;
  assign mem_to_reg_o = id_q.mem_to_reg;
  assign branch_o     = id_q.branch & id_q.valid;
  assign jump_o       = id_q.jump & id_q.valid;
  assign alu_ctrl_o   = id_q.alu_ctrl;
  assign illegal_o    = id_q.illegal;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_pipe
//
// Directed bench for fetch_decode_pipe (RESET_PC = 0x100). Each fetched word
// pushes its expected ID bundle into a queue; after the clock edge the bundle
// is popped and compared field by field against the ID outputs.
// -----------------------------------------------------------------------------
module tb_fetch_decode_pipe;

  localparam logic [31:0] RST_PC = 32'h100;

  // control-bit order: reg_write, alu_src, mem_write, mem_to_reg, branch, jump
  localparam logic [5:0] RW = 6'b100000;
  localparam logic [5:0] AS = 6'b010000;
  localparam logic [5:0] MW = 6'b001000;
  localparam logic [5:0] MR = 6'b000100;
  localparam logic [5:0] BR = 6'b000010;
  localparam logic [5:0] JP = 6'b000001;

  typedef struct packed {
    logic        valid;
    logic        ill;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [5:0]  ctl;
    logic [2:0]  alu;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_data_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] imm_o;
  logic        reg_write_o, alu_src_o, mem_write_o, mem_to_reg_o, branch_o, jump_o;
  logic [2:0]  alu_ctrl_o;
  logic        illegal_o;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t last;
  logic [31:0] tpc;

  fetch_decode_pipe #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .instr_addr_o(instr_addr_o),
    .instr_data_i(instr_data_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o),
    .reg_write_o(reg_write_o), .alu_src_o(alu_src_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .branch_o(branch_o), .jump_o(jump_o),
    .alu_ctrl_o(alu_ctrl_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ctl_now();
    return {reg_write_o, alu_src_o, mem_write_o, mem_to_reg_o, branch_o, jump_o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [5:0] ctl, input logic [2:0] alu);
    exp_t e;
    e.valid = 1'b1; e.ill = 1'b0; e.pc = '0;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.ctl = ctl; e.alu = alu;
    return e;
  endfunction

  task automatic cmp_bundle(input string tag, input exp_t e);
    chk({tag, ".valid"}, 64'(id_valid_o), 64'(e.valid));
    chk({tag, ".illegal"}, 64'(illegal_o), 64'(e.ill));
    chk({tag, ".pc"}, 64'(id_pc_o), 64'(e.pc));
    chk({tag, ".rd"}, 64'(rd_o), 64'(e.rd));
    chk({tag, ".rs1"}, 64'(rs1_o), 64'(e.rs1));
    chk({tag, ".rs2"}, 64'(rs2_o), 64'(e.rs2));
    chk({tag, ".imm"}, 64'(imm_o), 64'(e.imm));
    chk({tag, ".ctl"}, 64'(ctl_now()), 64'(e.ctl));
    chk({tag, ".alu"}, 64'(alu_ctrl_o), 64'(e.alu));
  endtask

  // Fetch one word at the model PC, expect it in ID after the edge
  task automatic issue(input string tag, input logic [31:0] word, input exp_t e);
    exp_t got;
    e.pc = tpc;
    sb_q.push_back(e);
    instr_data_i = word;
    step();
    tpc = tpc + 32'd4;
    chk({tag, ".addr"}, 64'(instr_addr_o), 64'(tpc));
    if (sb_q.size() != 0) begin
      got = sb_q.pop_front();
      cmp_bundle(tag, got);
      last = got;
    end else begin
      chk({tag, ".sb_empty"}, 64'(1), 64'(0));
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 64'(id_valid_o), 64'(0));
    chk({tag, ".gated"}, 64'({reg_write_o, mem_write_o, branch_o, jump_o}), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; instr_data_i = '0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    chk("rst.addr", 64'(instr_addr_o), 64'(RST_PC));
    chk("rst.valid", 64'(id_valid_o), 64'(0));
    chk("rst.ctl", 64'({ctl_now(), alu_ctrl_o}), 64'(0));
    chk("rst.imm", 64'(imm_o), 64'(0));
    chk("rst.regs", 64'({rs1_o, rs2_o, rd_o}), 64'(0));
    chk("rst.pc", 64'(id_pc_o), 64'(0));
    chk("rst.illegal", 64'(illegal_o), 64'(0));
    rst_n = 1'b1;
    tpc = RST_PC;

    // mixed instruction stream
    issue("addi",  32'h00500093, mk(5'd1,  5'd0, 5'd5,  32'h00000005, RW|AS,    3'b000));
    issue("beq",   32'hFE208CE3, mk(5'd25, 5'd1, 5'd2,  32'hFFFFFFF8, BR,       3'b001));
    issue("sub",   32'h402081B3, mk(5'd3,  5'd1, 5'd2,  32'h00000000, RW,       3'b001));
    issue("sw",    32'h0020A423, mk(5'd8,  5'd1, 5'd2,  32'h00000008, AS|MW,    3'b000));

    // stall holds PC and ID for three cycles even with an illegal word on the bus
    stall_i = 1'b1;
    instr_data_i = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.addr", 64'(instr_addr_o), 64'(tpc));
      cmp_bundle("stall", last);
    end

    // redirect wins over stall, one bubble
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step();
    stall_i = 1'b0; redirect_i = 1'b0;
    tpc = 32'h200;
    chk("redir.addr", 64'(instr_addr_o), 64'(tpc));
    chk_bubble("redir");

    issue("lui",   32'h123452B7, mk(5'd5,  5'd0, 5'd3,  32'h12345000, RW|AS,    3'b000));
    issue("jal",   32'h010000EF, mk(5'd1,  5'd0, 5'd16, 32'h00000010, RW|JP,    3'b000));
    issue("lw",    32'hFFC12203, mk(5'd4,  5'd2, 5'd28, 32'hFFFFFFFC, RW|AS|MR, 3'b000));

    // PC wrap at the top of the address space
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFFFFFC;
    step();
    redirect_i = 1'b0;
    tpc = 32'hFFFFFFFC;
    chk_bubble("wrapredir");
    issue("wrap",  32'h00500093, mk(5'd1,  5'd0, 5'd5,  32'h00000005, RW|AS,    3'b000));
    chk("wrap.zero", 64'(instr_addr_o), 64'(0));

    // illegal word
    instr_data_i = 32'hFFFFFFFF;
    step();
    tpc = tpc + 32'd4;
    chk("ill.addr", 64'(instr_addr_o), 64'(tpc));
    chk("ill.flag", 64'(illegal_o), 64'(1));
    chk_bubble("ill");
`ifdef ILLEGAL_TRAP_EN
    // HALT ignores redirect and stall; everything frozen
    instr_data_i = 32'h00500093;
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    step();
    chk("halt.redir.addr", 64'(instr_addr_o), 64'(tpc));
    chk("halt.redir.flag", 64'(illegal_o), 64'(1));
    redirect_i = 1'b0; stall_i = 1'b1;
    step();
    stall_i = 1'b0;
    step();
    chk("halt.addr", 64'(instr_addr_o), 64'(tpc));
    chk("halt.flag", 64'(illegal_o), 64'(1));
    chk_bubble("halt");
`else
    // pulse only; fetch continues
    issue("postill", 32'h00500093, mk(5'd1, 5'd0, 5'd5, 32'h00000005, RW|AS, 3'b000));
`endif

    // async reset mid-stall/redirect, sampled before the next edge
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h400;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.addr", 64'(instr_addr_o), 64'(RST_PC));
    chk("arst.valid", 64'(id_valid_o), 64'(0));
    chk("arst.illegal", 64'(illegal_o), 64'(0));
    chk("arst.pc", 64'(id_pc_o), 64'(0));
    chk("arst.imm", 64'(imm_o), 64'(0));
    chk("arst.ctl", 64'({ctl_now(), rd_o}), 64'(0));
    step();
    rst_n = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
    tpc = RST_PC;
    issue("restart", 32'h00500093, mk(5'd1, 5'd0, 5'd5, 32'h00000005, RW|AS, 3'b000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_pipe.md
# fetch_decode_pipe

Parametrised instruction-fetch and decode front end with a registered IF/ID boundary. It owns the program counter, drives the instruction-memory address, and decodes the returned word into a registered control/operand bundle for the execute stage. It also handles stall, branch/jump redirect with bubble insertion, and optional illegal-instruction halting. It replaces the purely combinational fetch/decode path and sits between instruction memory and the register file/ALU.

## Interface
- ADDRESS_WIDTH, 32, PC and instruction-address width.
- DATA_WIDTH, 32, instruction and immediate width.
- RESET_PC, 0, PC value loaded on reset (ADDRESS_WIDTH bits).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- stall_i  input  1  hold PC and IF/ID register.
- redirect_i  input  1  taken branch/jump resolved downstream.
- redirect_pc_i  input  ADDRESS_WIDTH  redirect target.
- instr_addr_o  output  ADDRESS_WIDTH  combinational copy of PC.
- instr_data_i  input  DATA_WIDTH  instruction word, valid in the same cycle as instr_addr_o.
- id_valid_o  output  1  ID bundle holds a real instruction.
- id_pc_o  output  ADDRESS_WIDTH  PC of the ID instruction.
- rs1_o, rs2_o, rd_o  output  5 each  register indices.
- imm_o  output  DATA_WIDTH  sign-extended immediate.
- reg_write_o, alu_src_o, mem_write_o, mem_to_reg_o, branch_o, jump_o  output  1 each  control bits.
- alu_ctrl_o  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- illegal_o  output  1  illegal-instruction flag.

## Operation
- Decoded opcodes:
  - 0110011 R-type: add/sub/and/or/xor/slt/sll/srl, selected by funct3 and funct7[5].
  - 0010011 I-ALU: same ops, no sub; alu_src=1.
  - 0000011 load: add, alu_src=1, mem_to_reg=1.
  - 0100011 store: add, alu_src=1, mem_write=1, reg_write=0.
  - 1100011 branch (funct3 000 beq, 001 bne): sub, branch=1.
  - 0110111 lui: imm=U, alu_src=1; rs1 forced to 0.
  - 1101111 jal: jump=1, reg_write=1.
- Immediate formats:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U = {instr[31:12], 12'b0}.
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Any other opcode, or an unlisted funct3/funct7 combination, is illegal.
- Update priority at each clock edge:
  1. redirect_i: pc <= redirect_pc_i; id_valid <= 0. A redirect beats a stall.
  2. stall_i: PC and all ID registers hold.
  3. Otherwise: pc <= pc + 4, modulo 2^ADDRESS_WIDTH. ID registers load the decode of instr_data_i, id_pc <= pc, id_valid <= 1.
- When id_valid_o=0, reg_write_o, mem_write_o, branch_o and jump_o are forced to 0 (bubble).
- State machine has two states, RUN and HALT. HALT exists only with the macro defined (see Configuration).

## Timing
- Reset (async assert, sync-safe deassert) drives:
  - pc = RESET_PC, so instr_addr_o = RESET_PC.
  - id_valid_o = 0, every control bit = 0, imm_o = 0, rs/rd = 0, id_pc_o = 0.
  - illegal_o = 0, state RUN.
- Fetch-to-ID latency is 1 cycle: the word at address A appears on the ID outputs the cycle after instr_addr_o = A, unless stalled.
- Redirect penalty is 1 bubble. The target's instruction reaches ID 2 edges after redirect_i is sampled.
- A reset mid-stall or mid-redirect discards everything; the next fetch is from RESET_PC.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An illegal decode in RUN (not stalled, not redirected) loads id_valid=0 and sets illegal_o=1.
  - The block enters HALT and illegal_o stays high.
  - In HALT the PC freezes at the offending address + 4, and id_valid stays 0.
  - redirect_i and stall_i are ignored in HALT. Only rst_n exits.
- ILLEGAL_TRAP_EN undefined:
  - An illegal word becomes a bubble (id_valid=0) and fetch continues at pc+4.
  - illegal_o pulses high for that one ID cycle.
  - No HALT state exists.

## Test plan
- Reset with RESET_PC=0x100, release, feed addi x1,x0,5 (0x00500093) -> next cycle id_valid=1, rd=1, imm=5, alu_ctrl=000, alu_src=1, reg_write=1, id_pc=0x100; instr_addr=0x104.
- Feed beq x1,x2,-8 (0xFE208CE3) -> imm=0xFFFFFFF8, branch=1, alu_ctrl=001, reg_write=0.
- stall_i high for 3 cycles -> instr_addr and all ID outputs constant. Same cycle as stall plus redirect_i to 0x200 -> pc=0x200, id_valid=0.
- PC at 0xFFFFFFFC with no stall -> wraps to 0x00000000.
- Word 0xFFFFFFFF with ILLEGAL_TRAP_EN -> illegal_o=1 sticky, PC frozen, redirect ignored. Without the macro -> one-cycle illegal_o pulse, bubble, fetch continues.
- Assert rst_n low mid-operation, asynchronously between edges -> outputs reach reset values immediately, before the next edge.
